ro_puf_ctrl: RTL and testbench

- Parametrised ring-oscillator PUF measurement controller; next generation of the fixed 8-bit-challenge PUF core.
- Takes NUM_RO free-running oscillator outputs and a challenge. For each response bit it selects an oscillator pair, counts rising edges of both over WINDOW clocks, and compares the counts.
- Assembles a RESP_BITS-wide response with start/busy/done handshake. Sits between the RO array and the key/ID consumer logic.

---
 rtl/ro_puf_ctrl_if.sv | 18 +
 rtl/ro_puf_ctrl.sv | 159 +++++++++++++++
 tb/tb_ro_puf_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ro_puf_ctrl_if.sv
// Request/response bundle between the RO PUF controller and its consumer.
interface ro_puf_ctrl_if #(
   parameter int CHAL_W    = 8,
   parameter int RESP_BITS = 8
);
   // start is a request sampled only while the controller is idle (not queued);
   // busy covers the evaluation, done pulses once when response/tie/valid update.
   logic                 start;
   logic [CHAL_W-1:0]    challenge;
   logic                 busy;
   logic                 done;
   logic                 valid;
   logic                 tie;
   logic [RESP_BITS-1:0] response;

   modport master (output start, challenge, input busy, done, valid, tie, response);
   modport slave  (input start, challenge, output busy, done, valid, tie, response);
endinterface

// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF controller: counts edges of an oscillator pair per response bit.
// Optional RO_PUF_MAJORITY_EN: three measurements per bit, majority vote.
module ro_puf_ctrl #(
   parameter int NUM_RO    = 16,
   parameter int CHAL_W    = 8,
   parameter int RESP_BITS = 8,
   parameter int WINDOW    = 1024,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_RO-1:0] ro,
   ro_puf_ctrl_if.slave      bus,
   output logic [2:0]        state_dbg
);
   localparam int NPAIR = NUM_RO / 2;
   localparam int PW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
   localparam int IW    = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
   localparam int WW    = $clog2(WINDOW + 1);

   typedef enum logic [2:0] {IDLE, CLEAR, MEASURE, COMPARE, DONE} state_t;
   state_t state, state_n;

   logic [NUM_RO-1:0]    sync1, sync_q, sync_qq, edges;
   logic                 req_q;
   logic [PW-1:0]        chal_q, chal;
   logic [IW-1:0]        idx;
   logic [PW-1:0]        pair;
   logic                 edge_a, edge_b;
   logic [CNT_W-1:0]     cnt_a, cnt_b;
   logic [WW-1:0]        wcnt;
   logic [RESP_BITS-1:0] shadow, shadow_n, response_r;
   logic                 tie_acc, tie_r, valid_r;
   logic                 gt, eq, bit_val, last_bit, last_run;
`ifdef RO_PUF_MAJORITY_EN
   logic [1:0]           run, votes;
`endif

   assign edges  = sync_q & ~sync_qq;
   // Pair index is the low bits of challenge + step; carries out of the pair field are dropped.
   assign pair   = chal + PW'(idx);
   assign edge_a = edges[{pair, 1'b0}];
   assign edge_b = edges[{pair, 1'b1}];
   assign gt     = (cnt_a > cnt_b);
   assign eq     = (cnt_a == cnt_b);
   assign last_bit = (idx == IW'(RESP_BITS - 1));

`ifdef RO_PUF_MAJORITY_EN
   assign last_run = (run == 2'd2);
   assign bit_val  = ((votes + 2'(gt)) >= 2'd2);
`else
   assign last_run = 1'b1;
   assign bit_val  = gt;
`endif

   always_comb begin
      shadow_n      = shadow;
      shadow_n[idx] = bit_val;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (req_q) state_n = CLEAR;
         CLEAR:   state_n = MEASURE;
         MEASURE: if (wcnt == WW'(1)) state_n = COMPARE;
         COMPARE: state_n = (last_run && last_bit) ? DONE : CLEAR;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1      <= '0;
         sync_q     <= '0;
         sync_qq    <= '0;
         req_q      <= 1'b0;
         chal_q     <= '0;
         chal       <= '0;
         idx        <= '0;
         cnt_a      <= '0;
         cnt_b      <= '0;
         wcnt       <= '0;
         shadow     <= '0;
         tie_acc    <= 1'b0;
         response_r <= '0;
         tie_r      <= 1'b0;
         valid_r    <= 1'b0;
`ifdef RO_PUF_MAJORITY_EN
         run        <= '0;
         votes      <= '0;
`endif
      end else begin
         sync1   <= ro;
         sync_q  <= sync1;
         sync_qq <= sync_q;
         // Requests register only while idle, so a start during an evaluation is dropped.
         req_q   <= bus.start && (state == IDLE);
         chal_q  <= bus.challenge[PW-1:0];
         case (state)
            IDLE: if (req_q) begin
               chal    <= chal_q;
               idx     <= '0;
               tie_acc <= 1'b0;
`ifdef RO_PUF_MAJORITY_EN
               run     <= '0;
               votes   <= '0;
`endif
            end
            CLEAR: begin
               cnt_a <= '0;
               cnt_b <= '0;
               wcnt  <= WW'(WINDOW);
            end
            MEASURE: begin
               wcnt <= wcnt - WW'(1);
               if (edge_a && (cnt_a != {CNT_W{1'b1}})) cnt_a <= cnt_a + CNT_W'(1);
               if (edge_b && (cnt_b != {CNT_W{1'b1}})) cnt_b <= cnt_b + CNT_W'(1);
            end
            COMPARE: begin
               tie_acc <= tie_acc | eq;
`ifdef RO_PUF_MAJORITY_EN
               if (!last_run) begin
                  run   <= run + 2'd1;
                  votes <= votes + 2'(gt);
               end else begin
                  run   <= '0;
                  votes <= '0;
               end
`endif
               if (last_run) begin
                  shadow <= shadow_n;
                  if (!last_bit) idx <= idx + IW'(1);
                  else begin
                     // Publish together with entering DONE so done sees the new result.
                     response_r <= shadow_n;
                     tie_r      <= tie_acc | eq;
                     valid_r    <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy     = (state != IDLE) && (state != DONE);
   assign bus.done     = (state == DONE);
   assign bus.valid    = valid_r;
   assign bus.tie      = tie_r;
   assign bus.response = response_r;
   assign state_dbg    = state;
endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Bench for ro_puf_ctrl: frequency-level model of the expected response plus directed checks.
module tb_ro_puf_ctrl;
   localparam int NUM_RO = 4, CHAL_W = 8, RESP_BITS = 4, WINDOW = 16, CNT_W = 16;
`ifdef RO_PUF_MAJORITY_EN
   localparam int RUNS = 3;
`else
   localparam int RUNS = 1;
`endif
   localparam int LAT = 1 + RUNS * RESP_BITS * (WINDOW + 2);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NUM_RO-1:0] ro  = '0;
   logic [2:0]        state_dbg;
   int                total = 0;
   int                bad = 0;
   int                cyc = 0;
   int                ro_per[NUM_RO];

   ro_puf_ctrl_if #(.CHAL_W(CHAL_W), .RESP_BITS(RESP_BITS)) bus();

   ro_puf_ctrl #(.NUM_RO(NUM_RO), .CHAL_W(CHAL_W), .RESP_BITS(RESP_BITS),
                 .WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .ro(ro), .bus(bus), .state_dbg(state_dbg));

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // oscillator stimulus: period in clk cycles, 0 = held low
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < NUM_RO; k++)
            ro[k] = (ro_per[k] == 0) ? 1'b0 : (((cyc / (ro_per[k] / 2)) % 2) != 0);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   // model: rising edges in a window = WINDOW / period; faster oscillator wins the bit
   int                   m_age = -1;
   logic [CHAL_W-1:0]    m_chal = '0;
   logic                 exp_busy = 1'b0, exp_done = 1'b0, exp_valid = 1'b0, exp_tie = 1'b0;
   logic [RESP_BITS-1:0] exp_resp = '0;
   logic [RESP_BITS-1:0] exp_q[$];

   function automatic int win_edges(input int k);
      return (ro_per[k] == 0) ? 0 : WINDOW / ro_per[k];
   endfunction

   always @(posedge clk) begin
      logic [CHAL_W-1:0] s;
      int p, ea, eb;
      if (rst) begin
         m_age = -1; exp_done = 0; exp_valid = 0; exp_tie = 0; exp_resp = '0;
      end else begin
         exp_done = 0;
         if (m_age < 0) begin
            if (bus.start) begin m_age = 0; m_chal = bus.challenge; end
         end else begin
            m_age++;
            if (m_age == LAT) begin
               exp_done = 1; exp_valid = 1; exp_tie = 0;
               for (int i = 0; i < RESP_BITS; i++) begin
                  s  = m_chal + CHAL_W'(i);
                  p  = int'(s) % (NUM_RO / 2);
                  ea = win_edges(2 * p);
                  eb = win_edges(2 * p + 1);
                  exp_resp[i] = (ea > eb);
                  if (ea == eb) exp_tie = 1;
               end
               exp_q.push_back(exp_resp);
            end else if (m_age == LAT + 1) m_age = -1;
         end
      end
      exp_busy = (m_age >= 1) && (m_age < LAT);
   end

   // scoreboard: compare every cycle, and pop a queued response on each done
   initial begin
      forever begin
         @(posedge clk); #1;
         check("busy", 32'(bus.busy), 32'(exp_busy));
         check("done", 32'(bus.done), 32'(exp_done));
         check("valid", 32'(bus.valid), 32'(exp_valid));
         check("tie", 32'(bus.tie), 32'(exp_tie));
         check("response", 32'(bus.response), 32'(exp_resp));
         if (bus.done && exp_q.size() > 0) check("sb_resp", 32'(bus.response), 32'(exp_q.pop_front()));
      end
   end

   // driver tasks
   task automatic pulse_start(input logic [7:0] c, output int t);
      @(negedge clk);
      bus.start = 1'b1; bus.challenge = c;
      @(posedge clk); #1 t = cyc;
      @(negedge clk);
      bus.start = 1'b0; bus.challenge = 8'($urandom_range(0, 255));
   endtask

   task automatic wait_done(input int t0, output int td);
      td = -1;
      for (int n = 0; n < LAT + 20; n++) begin
         @(posedge clk); #1;
         if (bus.done) begin td = cyc; break; end
      end
      if (td < 0) begin
         total++; bad++;
         $display("FAIL done_timeout actual=none required=done within %0d cycles", LAT + 20);
      end else check("latency", 32'(td - t0), 32'(LAT));
   endtask

   task automatic count_done(input int n, output int cnt);
      cnt = 0;
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         if (bus.done) cnt++;
      end
   endtask

   task automatic set_ro(input int a, input int b, input int c, input int d);
      ro_per[0] = a; ro_per[1] = b; ro_per[2] = c; ro_per[3] = d;
   endtask

   typedef struct { logic [7:0] chal; bit held; logic [3:0] resp; logic tie; } vec_t;
   vec_t vecs[4] = '{
      '{8'h00, 1'b0, 4'b0101, 1'b0},
      '{8'h01, 1'b0, 4'b1010, 1'b0},
      '{8'hFF, 1'b0, 4'b1010, 1'b0},
      '{8'h00, 1'b1, 4'b0000, 1'b1}
   };

   initial begin
      int t0, td, nd;
      bus.start = 1'b0; bus.challenge = '0;
      set_ro(0, 0, 0, 0);
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_valid", 32'(bus.valid), 32'd0);
      check("rst_tie", 32'(bus.tie), 32'd0);
      check("rst_resp", 32'(bus.response), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      foreach (vecs[v]) begin
         if (vecs[v].held) set_ro(0, 0, 0, 0);
         else              set_ro(4, 8, 8, 4);
         repeat (4) @(negedge clk);
         pulse_start(vecs[v].chal, t0);
         wait_done(t0, td);
         check("vec_resp", 32'(bus.response), 32'(vecs[v].resp));
         check("vec_tie", 32'(bus.tie), 32'(vecs[v].tie));
         check("vec_valid", 32'(bus.valid), 32'd1);
         repeat (3) @(negedge clk);
      end

      // start during evaluation is ignored
      set_ro(4, 8, 8, 4);
      repeat (4) @(negedge clk);
      pulse_start(8'h00, t0);
      repeat (9) @(negedge clk);
      bus.start = 1'b1; bus.challenge = 8'h01;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(t0, td);
      check("ign_resp", 32'(bus.response), 32'h5);
      count_done(LAT + 10, nd);
      check("single_done", 32'(nd), 32'd0);

      // reset mid-evaluation
      pulse_start(8'h00, t0);
      repeat (39) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_valid", 32'(bus.valid), 32'd0);
      check("abort_resp", 32'(bus.response), 32'd0);
      count_done(LAT + 10, nd);
      check("abort_no_done", 32'(nd), 32'd0);
      pulse_start(8'h00, t0);
      wait_done(t0, td);
      check("after_abort_resp", 32'(bus.response), 32'h5);
      check("after_abort_valid", 32'(bus.valid), 32'd1);
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
